// File: rtl/adc_capture_sequencer.sv
// Sequences multi-frame ADC captures through the packetiser and reports run status.
// Define ADC_SEQ_TIMEOUT_EN to build the CAPTURE stall watchdog (TIMEOUT_CYCLES).
module adc_capture_sequencer #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] frame_len_i,
    input  logic [CNT_W-1:0] frame_cnt_i,
    input  logic [CNT_W-1:0] gap_i,
    input  logic             trig_mode_i,
    input  logic             trig_i,
    input  logic             axis_tvalid_i,
    input  logic             axis_tready_i,
    input  logic             axis_tlast_i,
    output logic             capture_en_o,
    output logic [CNT_W-1:0] length_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] frames_done_o,
    output logic             cfg_err_o,
    output logic             len_err_o,
    output logic             timeout_o
);
    typedef enum logic [1:0] {StIdle, StArm, StCapture, StGap} state_e;

    if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be non-zero");
    end

    state_e           state_q;
    logic [CNT_W-1:0] frame_len_q, frame_cnt_q, gap_q, beat_cnt_q, gap_cnt_q;
    logic [CNT_W-1:0] length_q, frames_done_q;
    logic             trig_mode_q, trig_q, trig_edge_q;
    logic             capture_en_q, busy_q, done_q, cfg_err_q, len_err_q;

    logic             beat, last_frame;
    logic [CNT_W-1:0] frames_inc;
    logic [CNT_W:0]   beats_in_frame;

    assign beat           = axis_tvalid_i & axis_tready_i;
    assign frames_inc     = frames_done_q + CNT_W'(1);
    assign last_frame     = (frames_inc == frame_cnt_q);
    // One bit wider so a saturated beat count can never alias a legal length
    assign beats_in_frame = {1'b0, beat_cnt_q} + (CNT_W + 1)'(1);

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int unsigned StallW = $clog2(TIMEOUT_CYCLES + 1);
    logic [StallW-1:0] stall_q;
    logic              timeout_q;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= StIdle;
            frame_len_q   <= '0;
            frame_cnt_q   <= '0;
            gap_q         <= '0;
            beat_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            length_q      <= '0;
            frames_done_q <= '0;
            trig_mode_q   <= 1'b0;
            trig_q        <= 1'b0;
            trig_edge_q   <= 1'b0;
            capture_en_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
            stall_q       <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            trig_q      <= trig_i;
            // Only edges that occur while armed may launch a frame
            trig_edge_q <= (state_q == StArm) & trig_i & ~trig_q;
`ifdef ADC_SEQ_TIMEOUT_EN
            if (state_q != StCapture) stall_q <= '0;
`endif
            if (abort_i) begin
                state_q      <= StIdle;
                capture_en_q <= 1'b0;
                busy_q       <= 1'b0;
                trig_edge_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            if (frame_len_i == '0 || frame_cnt_i == '0) begin
                                cfg_err_q <= 1'b1;
                            end else begin
                                frame_len_q   <= frame_len_i;
                                frame_cnt_q   <= frame_cnt_i;
                                gap_q         <= gap_i;
                                trig_mode_q   <= trig_mode_i;
                                length_q      <= frame_len_i - CNT_W'(1);
                                frames_done_q <= '0;
                                len_err_q     <= 1'b0;
                                beat_cnt_q    <= '0;
                                busy_q        <= 1'b1;
                                state_q       <= trig_mode_i ? StArm : StCapture;
                                capture_en_q  <= ~trig_mode_i;
`ifdef ADC_SEQ_TIMEOUT_EN
                                timeout_q     <= 1'b0;
`endif
                            end
                        end
                    end
                    StArm: begin
                        if (trig_edge_q) begin
                            state_q      <= StCapture;
                            capture_en_q <= 1'b1;
                            beat_cnt_q   <= '0;
                        end
                    end
                    StCapture: begin
                        if (beat) begin
                            if (beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
`ifdef ADC_SEQ_TIMEOUT_EN
                            stall_q <= '0;
`endif
                            if (axis_tlast_i) begin
                                if (beats_in_frame != {1'b0, frame_len_q}) len_err_q <= 1'b1;
                                frames_done_q <= frames_inc;
                                beat_cnt_q    <= '0;
                                if (last_frame) begin
                                    state_q      <= StIdle;
                                    capture_en_q <= 1'b0;
                                    busy_q       <= 1'b0;
                                    done_q       <= 1'b1;
                                end else if (gap_q == '0) begin
                                    state_q      <= trig_mode_q ? StArm : StCapture;
                                    capture_en_q <= ~trig_mode_q;
                                end else begin
                                    state_q      <= StGap;
                                    gap_cnt_q    <= '0;
                                    capture_en_q <= 1'b0;
                                end
                            end
                        end
`ifdef ADC_SEQ_TIMEOUT_EN
                        else if (stall_q == StallW'(TIMEOUT_CYCLES - 1)) begin
                            timeout_q    <= 1'b1;
                            state_q      <= StIdle;
                            capture_en_q <= 1'b0;
                            busy_q       <= 1'b0;
                        end else begin
                            stall_q <= stall_q + StallW'(1);
                        end
`endif
                    end
                    StGap: begin
                        // Counting from 0 keeps capture_en low gap+1 cycles between frames
                        if (gap_cnt_q == gap_q) begin
                            state_q      <= trig_mode_q ? StArm : StCapture;
                            capture_en_q <= ~trig_mode_q;
                            beat_cnt_q   <= '0;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign capture_en_o  = capture_en_q;
    assign length_o      = length_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign frames_done_o = frames_done_q;
    assign cfg_err_o     = cfg_err_q;
    assign len_err_o     = len_err_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed self-checking bench for adc_capture_sequencer.
module tb_adc_capture_sequencer;
    localparam int unsigned CNT_W = 32;

    logic             clk_i = 1'b0;
    logic             reset_ni;
    logic             start_i, abort_i, trig_mode_i, trig_i;
    logic [CNT_W-1:0] frame_len_i, frame_cnt_i, gap_i;
    logic             axis_tvalid_i, axis_tready_i, axis_tlast_i;
    logic             capture_en_o, busy_o, done_o, cfg_err_o, len_err_o, timeout_o;
    logic [CNT_W-1:0] length_o, frames_done_o;

    int errors = 0;
    int checks = 0;

    adc_capture_sequencer #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .frame_len_i    (frame_len_i),
        .frame_cnt_i    (frame_cnt_i),
        .gap_i          (gap_i),
        .trig_mode_i    (trig_mode_i),
        .trig_i         (trig_i),
        .axis_tvalid_i  (axis_tvalid_i),
        .axis_tready_i  (axis_tready_i),
        .axis_tlast_i   (axis_tlast_i),
        .capture_en_o   (capture_en_o),
        .length_o       (length_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .frames_done_o  (frames_done_o),
        .cfg_err_o      (cfg_err_o),
        .len_err_o      (len_err_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        start_i = 0; abort_i = 0; trig_i = 0; axis_tvalid_i = 0; axis_tlast_i = 0;
        axis_tready_i = 1;
    endtask

    task automatic test_reset();
        reset_ni = 0; idle_inputs(); trig_mode_i = 0;
        frame_len_i = 0; frame_cnt_i = 0; gap_i = 0;
        #12;
        checks++;
        if ({capture_en_o, busy_o, done_o, cfg_err_o, len_err_o, timeout_o, length_o,
             frames_done_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got en=%b busy=%b done=%b len=%0d frames=%0d, want all 0",
                     capture_en_o, busy_o, done_o, length_o, frames_done_o);
        end
        @(negedge clk_i); reset_ni = 1;
        tick();
        checks++;
        if (busy_o !== 1'b0 || capture_en_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b en=%b want 0 0", busy_o, capture_en_o);
        end
    endtask

    task automatic test_free_run();
        logic [24:0] en_obs, en_exp, done_obs, done_exp;
        frame_len_i = 4; frame_cnt_i = 3; gap_i = 2; trig_mode_i = 0;
        axis_tvalid_i = 1; axis_tready_i = 1;
        for (int i = 0; i < 25; i++) begin
            start_i      = (i == 0);
            axis_tlast_i = (i == 4 || i == 11 || i == 18);
            en_obs[i]    = capture_en_o;
            done_obs[i]  = done_o;
            en_exp[i]    = (i >= 1 && i <= 4) || (i >= 8 && i <= 11) || (i >= 15 && i <= 18);
            done_exp[i]  = (i == 19);
            if (i == 1) begin
                checks++;
                if (length_o !== 32'd3 || busy_o !== 1'b1) begin
                    errors++;
                    $display("FAIL free_length: got len=%0d busy=%b want 3 1", length_o, busy_o);
                end
            end
            tick();
        end
        idle_inputs();
        checks++;
        if (en_obs !== en_exp) begin
            errors++;
            $display("FAIL free_en_pattern: got %b want %b", en_obs, en_exp);
        end
        checks++;
        if (done_obs !== done_exp) begin
            errors++;
            $display("FAIL free_done_pattern: got %b want %b", done_obs, done_exp);
        end
        checks++;
        if (frames_done_o !== 32'd3 || busy_o !== 1'b0 || len_err_o !== 1'b0) begin
            errors++;
            $display("FAIL free_status: got frames=%0d busy=%b len_err=%b want 3 0 0",
                     frames_done_o, busy_o, len_err_o);
        end
    endtask

    task automatic test_triggered();
        logic [69:0] en_obs, en_exp, done_obs, done_exp;
        frame_len_i = 3; frame_cnt_i = 2; gap_i = 1; trig_mode_i = 1;
        axis_tvalid_i = 1; axis_tready_i = 1;
        for (int i = 0; i < 70; i++) begin
            start_i      = (i == 0);
            trig_i       = (i >= 20 && i <= 22) || (i >= 25 && i <= 26) || (i >= 60 && i <= 61);
            axis_tlast_i = (i == 24 || i == 64);
            en_obs[i]    = capture_en_o;
            done_obs[i]  = done_o;
            en_exp[i]    = (i >= 22 && i <= 24) || (i >= 62 && i <= 64);
            done_exp[i]  = (i == 65);
            if (i == 10) begin
                checks++;
                if (busy_o !== 1'b1 || length_o !== 32'd2) begin
                    errors++;
                    $display("FAIL trig_armed: got busy=%b len=%0d want 1 2", busy_o, length_o);
                end
            end
            tick();
        end
        idle_inputs(); trig_mode_i = 0;
        checks++;
        if (en_obs !== en_exp) begin
            errors++;
            $display("FAIL trig_en_pattern: got %b want %b", en_obs, en_exp);
        end
        checks++;
        if (done_obs !== done_exp || frames_done_o !== 32'd2) begin
            errors++;
            $display("FAIL trig_done: got done=%b frames=%0d want %b 2", done_obs,
                     frames_done_o, done_exp);
        end
    endtask

    task automatic test_len_err();
        frame_len_i = 8; frame_cnt_i = 1; gap_i = 0; trig_mode_i = 0;
        axis_tvalid_i = 1; axis_tready_i = 1;
        for (int i = 0; i < 9; i++) begin
            start_i      = (i == 0);
            axis_tlast_i = (i == 6);
            if (i == 6) begin
                checks++;
                if (len_err_o !== 1'b0 || capture_en_o !== 1'b1) begin
                    errors++;
                    $display("FAIL len_err_early: got len_err=%b en=%b want 0 1",
                             len_err_o, capture_en_o);
                end
            end
            if (i == 7) begin
                checks++;
                if (len_err_o !== 1'b1 || done_o !== 1'b1 || frames_done_o !== 32'd1 ||
                    busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL len_err_set: got len_err=%b done=%b frames=%0d busy=%b want 1 1 1 0",
                             len_err_o, done_o, frames_done_o, busy_o);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_cfg_err();
        frame_len_i = 0; frame_cnt_i = 3; start_i = 1;
        tick();
        start_i = 0;
        checks++;
        if (cfg_err_o !== 1'b1 || busy_o !== 1'b0 || len_err_o !== 1'b1) begin
            errors++;
            $display("FAIL cfg_len_zero: got cfg_err=%b busy=%b len_err=%b want 1 0 1",
                     cfg_err_o, busy_o, len_err_o);
        end
        tick();
        checks++;
        if (cfg_err_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL cfg_pulse_width: got cfg_err=%b busy=%b want 0 0", cfg_err_o, busy_o);
        end
        frame_len_i = 4; frame_cnt_i = 0; start_i = 1;
        tick();
        start_i = 0;
        checks++;
        if (cfg_err_o !== 1'b1 || busy_o !== 1'b0 || frames_done_o !== 32'd1) begin
            errors++;
            $display("FAIL cfg_cnt_zero: got cfg_err=%b busy=%b frames=%0d want 1 0 1",
                     cfg_err_o, busy_o, frames_done_o);
        end
        tick();
    endtask

    task automatic test_abort();
        logic [12:0] done_obs;
        frame_len_i = 5; frame_cnt_i = 2; gap_i = 0; trig_mode_i = 0; axis_tready_i = 1;
        for (int i = 0; i < 13; i++) begin
            start_i       = (i == 0);
            axis_tvalid_i = (i >= 1 && i <= 8);
            axis_tlast_i  = (i == 5 || i == 8);
            abort_i       = (i == 8);
            done_obs[i]   = done_o;
            if (i == 1) begin
                checks++;
                if (len_err_o !== 1'b0 || frames_done_o !== 32'd0) begin
                    errors++;
                    $display("FAIL abort_start_clear: got len_err=%b frames=%0d want 0 0",
                             len_err_o, frames_done_o);
                end
            end
            if (i == 6) begin
                checks++;
                if (capture_en_o !== 1'b1 || frames_done_o !== 32'd1) begin
                    errors++;
                    $display("FAIL abort_gap0_continue: got en=%b frames=%0d want 1 1",
                             capture_en_o, frames_done_o);
                end
            end
            if (i == 9) begin
                checks++;
                if (busy_o !== 1'b0 || capture_en_o !== 1'b0 || frames_done_o !== 32'd1 ||
                    len_err_o !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_idle: got busy=%b en=%b frames=%0d len_err=%b want 0 0 1 0",
                             busy_o, capture_en_o, frames_done_o, len_err_o);
                end
            end
            tick();
        end
        idle_inputs();
        checks++;
        if (done_obs !== 13'd0) begin
            errors++;
            $display("FAIL abort_no_done: got %b want all 0", done_obs);
        end
        frame_len_i = 2; frame_cnt_i = 1;
        for (int i = 0; i < 5; i++) begin
            start_i       = (i == 0);
            axis_tvalid_i = (i >= 1 && i <= 2);
            axis_tlast_i  = (i == 2);
            if (i == 1) begin
                checks++;
                if (length_o !== 32'd1 || frames_done_o !== 32'd0 || capture_en_o !== 1'b1) begin
                    errors++;
                    $display("FAIL restart_begin: got len=%0d frames=%0d en=%b want 1 0 1",
                             length_o, frames_done_o, capture_en_o);
                end
            end
            if (i == 3) begin
                checks++;
                if (done_o !== 1'b1 || frames_done_o !== 32'd1 || busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL restart_done: got done=%b frames=%0d busy=%b want 1 1 0",
                             done_o, frames_done_o, busy_o);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        frame_len_i = 10; frame_cnt_i = 1; gap_i = 0; trig_mode_i = 0;
        axis_tvalid_i = 1; start_i = 1;
        tick();
        start_i = 0;
        tick(); tick();
        checks++;
        if (capture_en_o !== 1'b1) begin
            errors++;
            $display("FAIL areset_precond: got en=%b want 1", capture_en_o);
        end
        #2 reset_ni = 0;
        #1;
        checks++;
        if ({capture_en_o, busy_o, done_o, length_o, frames_done_o} !== '0) begin
            errors++;
            $display("FAIL areset_clear: got en=%b busy=%b len=%0d frames=%0d want all 0",
                     capture_en_o, busy_o, length_o, frames_done_o);
        end
        idle_inputs();
        @(negedge clk_i); reset_ni = 1;
        tick();
    endtask

    task automatic test_stall();
        frame_len_i = 4; frame_cnt_i = 1; gap_i = 0; trig_mode_i = 0;
        axis_tvalid_i = 1; axis_tready_i = 0;
`ifdef ADC_SEQ_TIMEOUT_EN
        for (int i = 0; i < 20; i++) begin
            start_i = (i == 0);
            if (i == 16) begin
                checks++;
                if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
                    errors++;
                    $display("FAIL wdog_early: got timeout=%b busy=%b want 0 1", timeout_o, busy_o);
                end
            end
            if (i == 17) begin
                checks++;
                if (timeout_o !== 1'b1 || busy_o !== 1'b0 || capture_en_o !== 1'b0 ||
                    done_o !== 1'b0) begin
                    errors++;
                    $display("FAIL wdog_fire: got timeout=%b busy=%b en=%b done=%b want 1 0 0 0",
                             timeout_o, busy_o, capture_en_o, done_o);
                end
            end
            tick();
        end
`else
        for (int i = 0; i < 41; i++) begin
            start_i = (i == 0);
            tick();
        end
        checks++;
        if (timeout_o !== 1'b0 || busy_o !== 1'b1 || capture_en_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_wait: got timeout=%b busy=%b en=%b want 0 1 1",
                     timeout_o, busy_o, capture_en_o);
        end
        abort_i = 1;
        tick();
        abort_i = 0;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_abort: got busy=%b done=%b want 0 0", busy_o, done_o);
        end
`endif
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_triggered();
        test_len_err();
        test_cfg_err();
        test_abort();
        test_async_reset();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
